// File: rtl/opb_pkg.sv
// ============================================================================
// Module   : opb_pkg
// Brief    : Shared types and constants for the OPB serial input feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package opb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } opb_state_t;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int WORDCOUNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/opb_bit_sync.sv
// ============================================================================
// Module   : opb_bit_sync
// Brief    : Multi-flop synchroniser bringing one pad signal into the clk domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opb_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/opb_serial_in.sv
// ============================================================================
// Module   : opb_serial_in
// Brief    : Deserialises a framed pad bitstream into WIDTH-bit OPB lane words.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module opb_serial_in
  import opb_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   UserCLK,
  input  logic                   Reset,
  input  logic                   SER_D,
  input  logic                   SER_FRAME,
  input  logic                   OPB_Hold,
  input  logic                   ErrClr,
  output logic [WIDTH-1:0]       OPB_I,
  output logic                   OPB_Valid,
  output logic [1:0]             Err,
  output logic [WORDCOUNT_W-1:0] WordCount
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  logic w_d_s;
  logic w_f_s;

  opb_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_d (
    .clk (UserCLK),
    .rst (Reset),
    .i_d (SER_D),
    .o_q (w_d_s)
  );

  opb_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_f (
    .clk (UserCLK),
    .rst (Reset),
    .i_d (SER_FRAME),
    .o_q (w_f_s)
  );

  opb_state_t             r_state;
  opb_state_t             w_state_nxt;
  logic [WIDTH-2:0]       r_sh;
  logic [WIDTH-2:0]       w_sh_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_done;
  logic                   w_frame_err;
  logic [WIDTH-1:0]       w_word;
  logic [1:0]             w_err_set;

  logic [WIDTH-1:0]       r_opb_i;
  logic                   r_valid;
  logic [1:0]             r_err;
  logic [WORDCOUNT_W-1:0] r_wordcount;

  assign w_word = {w_d_s, r_sh};

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_f_s) begin
          w_sh_nxt[0] = w_d_s;
          w_cnt_nxt   = C_CNT_ONE;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // A strobe mid-frame restarts capture with this bit as bit 0.
        if (w_f_s) begin
          w_frame_err = 1'b1;
          w_sh_nxt[0] = w_d_s;
          w_cnt_nxt   = C_CNT_ONE;
        end else if (r_cnt == C_CNT_LAST) begin
          w_done      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_sh_nxt[r_cnt] = w_d_s;
          w_cnt_nxt       = r_cnt + C_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_FRAME]   = w_frame_err;
    w_err_set[ERR_OVERRUN] = w_done & OPB_Hold;
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      r_opb_i     <= '0;
      r_valid     <= 1'b0;
      r_err       <= '0;
      r_wordcount <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_done && !OPB_Hold) begin
        r_opb_i     <= w_word;
        r_valid     <= 1'b1;
        r_wordcount <= r_wordcount + WORDCOUNT_W'(1);
      end
      // A flag being set in this cycle survives a simultaneous clear.
      r_err <= (r_err & ~{2{ErrClr}}) | w_err_set;
    end
  end

  assign OPB_I     = r_opb_i;
  assign OPB_Valid = r_valid;
  assign Err       = r_err;
  assign WordCount = r_wordcount;

endmodule

`default_nettype wire

// File: tb/tb_opb_serial_in.sv
// ============================================================================
// Module   : tb_opb_serial_in
// Brief    : Scoreboard bench for opb_serial_in (word, count, latency, errors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_opb_serial_in;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int LAT   = SYNC + WIDTH;

  logic             UserCLK = 1'b0;
  logic             Reset = 1'b1;
  logic             SER_D = 1'b0;
  logic             SER_FRAME = 1'b0;
  logic             OPB_Hold = 1'b0;
  logic             ErrClr = 1'b0;
  logic [WIDTH-1:0] OPB_I;
  logic             OPB_Valid;
  logic [1:0]       Err;
  logic [7:0]       WordCount;

  opb_serial_in #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .UserCLK   (UserCLK),
    .Reset     (Reset),
    .SER_D     (SER_D),
    .SER_FRAME (SER_FRAME),
    .OPB_Hold  (OPB_Hold),
    .ErrClr    (ErrClr),
    .OPB_I     (OPB_I),
    .OPB_Valid (OPB_Valid),
    .Err       (Err),
    .WordCount (WordCount)
  );

  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [7:0]       wc;
    int               cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_wc = 8'd0;

  always @(posedge UserCLK) cyc = cyc + 1;

  always @(posedge UserCLK) begin
    exp_t e;
    #1;
    if (OPB_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: OPB_Valid=1 with no word pending, OPB_I=%h cycle=%0d", OPB_I, cyc);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (OPB_I !== e.word) begin
          n_fail++;
          $display("FAIL word: OPB_I=%h expected %h", OPB_I, e.word);
        end
        n_checks++;
        if (WordCount !== e.wc) begin
          n_fail++;
          $display("FAIL wordcount_at_valid: WordCount=%0d expected %0d", WordCount, e.wc);
        end
        n_checks++;
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL latency: valid at cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge UserCLK);
      SER_D     = 1'b0;
      SER_FRAME = 1'b0;
      ErrClr    = 1'b0;
    end
  endtask

  task automatic send_partial(input logic [WIDTH-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge UserCLK);
      SER_D     = w[i];
      SER_FRAME = (i == 0);
      ErrClr    = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input bit deliver, input int clr_at);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge UserCLK);
      SER_D     = w[i];
      SER_FRAME = (i == 0);
      ErrClr    = (i == clr_at);
      if (i == 0 && deliver) begin
        exp_wc = exp_wc + 8'd1;
        sb.push_back('{w, exp_wc, cyc + LAT});
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    idle(2);
    while (sb.size() != 0 && t < 64) begin
      @(negedge UserCLK);
      t++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words never delivered, expected 0 pending", sb.size());
      sb.delete();
    end
    idle(4);
  endtask

  task automatic pulse_errclr();
    @(negedge UserCLK);
    ErrClr = 1'b1;
    @(negedge UserCLK);
    ErrClr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (OPB_I !== '0 || OPB_Valid !== 1'b0 || Err !== 2'b00 || WordCount !== 8'd0) begin
      n_fail++;
      $display("FAIL %s: OPB_I=%h Valid=%b Err=%b WordCount=%0d expected all zero",
               tag, OPB_I, OPB_Valid, Err, WordCount);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle(3);
    @(negedge UserCLK);
    Reset = 1'b0;
    sb.delete();
    exp_wc = 8'd0;
    check_all_zero("reset_state");
  endtask

  task automatic test_single();
    send_frame(4'b1101, 1'b1, -1);
    drain();
    n_checks++;
    if (OPB_I !== 4'hD) begin
      n_fail++;
      $display("FAIL single_word: OPB_I=%h expected d", OPB_I);
    end
    n_checks++;
    if (WordCount !== 8'd1) begin
      n_fail++;
      $display("FAIL single_count: WordCount=%0d expected 1", WordCount);
    end
    n_checks++;
    if (Err !== 2'b00) begin
      n_fail++;
      $display("FAIL single_err: Err=%b expected 00", Err);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(4'h3, 1'b1, -1);
    send_frame(4'hC, 1'b1, -1);
    send_frame(4'hF, 1'b1, -1);
    drain();
    n_checks++;
    if (WordCount !== exp_wc || Err !== 2'b00 || OPB_I !== 4'hF) begin
      n_fail++;
      $display("FAIL b2b_final: OPB_I=%h WordCount=%0d Err=%b expected f %0d 00",
               OPB_I, WordCount, Err, exp_wc);
    end
  endtask

  task automatic test_premature();
    send_partial(4'h7, 2);
    send_frame(4'hA, 1'b1, -1);
    drain();
    n_checks++;
    if (Err !== 2'b01 || OPB_I !== 4'hA) begin
      n_fail++;
      $display("FAIL premature: Err=%b OPB_I=%h expected 01 a", Err, OPB_I);
    end
    pulse_errclr();
    idle(1);
    n_checks++;
    if (Err !== 2'b00) begin
      n_fail++;
      $display("FAIL premature_clr: Err=%b expected 00", Err);
    end
  endtask

  task automatic test_hold();
    logic [7:0] wc_before;
    send_frame(4'h9, 1'b1, -1);
    drain();
    wc_before = exp_wc;
    OPB_Hold = 1'b1;
    send_frame(4'h5, 1'b0, -1);
    idle(8);
    OPB_Hold = 1'b0;
    n_checks++;
    if (OPB_I !== 4'h9 || WordCount !== wc_before || Err !== 2'b10) begin
      n_fail++;
      $display("FAIL hold: OPB_I=%h WordCount=%0d Err=%b expected 9 %0d 10",
               OPB_I, WordCount, Err, wc_before);
    end
    pulse_errclr();
    idle(1);
    n_checks++;
    if (Err !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_clr: Err=%b expected 00", Err);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(4'(i), 1'b1, -1);
    end
    drain();
    n_checks++;
    if (WordCount !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap: WordCount=%0d expected 0", WordCount);
    end
  endtask

  task automatic test_err_priority();
    OPB_Hold = 1'b1;
    send_frame(4'h1, 1'b0, -1);
    idle(8);
    OPB_Hold = 1'b0;
    n_checks++;
    if (Err !== 2'b10) begin
      n_fail++;
      $display("FAIL prio_setup: Err=%b expected 10", Err);
    end
    send_partial(4'h2, 2);
    send_frame(4'h3, 1'b1, 2);
    drain();
    n_checks++;
    if (Err !== 2'b01 || OPB_I !== 4'h3) begin
      n_fail++;
      $display("FAIL prio: Err=%b OPB_I=%h expected 01 3", Err, OPB_I);
    end
  endtask

  task automatic test_reset_midframe();
    send_partial(4'h6, 2);
    @(negedge UserCLK);
    Reset     = 1'b1;
    SER_FRAME = 1'b0;
    SER_D     = 1'b1;
    @(negedge UserCLK);
    Reset = 1'b0;
    sb.delete();
    exp_wc = 8'd0;
    idle(8);
    check_all_zero("reset_midframe");
    send_frame(4'h6, 1'b1, -1);
    drain();
    n_checks++;
    if (OPB_I !== 4'h6 || WordCount !== 8'd1 || Err !== 2'b00) begin
      n_fail++;
      $display("FAIL after_reset: OPB_I=%h WordCount=%0d Err=%b expected 6 1 00",
               OPB_I, WordCount, Err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_premature();
    test_hold();
    test_wrap();
    test_err_priority();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
